xgmii_rx_latency: RTL and testbench



---
 rtl/measure_pkg.sv | 35 +++
 rtl/xgmii_term_lane.sv | 24 ++
 rtl/xgmii_rx_latency.sv | 175 +++++++++++++++++
 tb/tb_xgmii_rx_latency.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/measure_pkg.sv
// Shared constants and types for the XGMII RX measurement path.
package measure_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERR   = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    localparam logic [39:0] MAGIC_CODE_DEFAULT = 40'h01_23_45_67_89;

    // Word indices (start word is 0) carrying the fields of interest.
    localparam logic [7:0] IDX_ETH   = 8'd2;
    localparam logic [7:0] IDX_PROTO = 8'd3;
    localparam logic [7:0] IDX_SRCIP = 8'd4;
    localparam logic [7:0] IDX_MAGIC = 8'd6;
    localparam logic [7:0] IDX_TS    = 8'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic eth;
        logic proto;
        logic magic;
        logic ts;
    } tag_flags_t;

    function automatic logic [7:0] lane_byte(input logic [63:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/xgmii_term_lane.sv
// Finds the lowest XGMII lane carrying a terminate control character.
module xgmii_term_lane
    import measure_pkg::*;
(
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        term_hit,
    output logic [2:0]  term_lane
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        term_hit  = 1'b0;
        term_lane = 3'd0;
        // Scan downwards so the lowest matching lane wins.
        for (int k = 7; k >= 0; k--) begin
            if (xgmii_rxc[k] && lane_byte(xgmii_rxd, k) == XGMII_TERM) begin
                term_hit  = 1'b1;
                term_lane = 3'(k);
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_latency.sv
// XGMII RX consumer of magic-tagged UDP test frames: per-frame latency and
// source IP, per-second frame and byte rates, and an error counter.
module xgmii_rx_latency
    import measure_pkg::*;
#(
    parameter logic [39:0] MAGIC_CODE = MAGIC_CODE_DEFAULT,
    parameter logic [7:0]  MAX_WORDS  = 8'd192
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic        rx_lat_valid,
    output logic [31:0] rx_ipv4_ip,
    output logic [15:0] rx_err_count
);

    rx_state_t  state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic       term_hit;
    logic [2:0] term_lane;
    logic       is_start, all_idle, data_word;
    logic [15:0] frame_len;
    logic       frame_end, err_inc, restart;

    tag_flags_t flags_q;
    logic [7:0]  ts_hi_q;
    logic [31:0] src_ip_q;
    logic [31:0] lat32_q;
    logic [23:0] lat_sat;
    logic [31:0] frame_acc, byte_acc;
    logic [32:0] byte_sum;

    xgmii_term_lane u_term_lane (
        .xgmii_rxd (xgmii_rxd),
        .xgmii_rxc (xgmii_rxc),
        .term_hit  (term_hit),
        .term_lane (term_lane)
    );

    assign is_start  = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == XGMII_START);
    assign all_idle  = (xgmii_rxc == 8'hFF) && (xgmii_rxd == {8{XGMII_IDLE}});
    assign data_word = (state_q == ST_RECV) && (xgmii_rxc == 8'h00);
    assign frame_len = {5'd0, idx_q, 3'd0} + {13'd0, term_lane} - 16'd8;
    assign lat_sat   = (|lat32_q[31:24]) ? 24'hFF_FFFF : lat32_q[23:0];
    assign byte_sum  = {1'b0, byte_acc} + {17'd0, frame_len};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_inc   = 1'b0;
        frame_end = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d = ST_RECV;
                    idx_d   = 8'd1;
                    restart = 1'b1;
                end
            end
            ST_RECV: begin
                if (term_hit) begin
                    state_d = ST_IDLE;
                    idx_d   = 8'd0;
                    // A terminate right after the start carries no bytes.
                    if (frame_len == 16'd0) err_inc   = 1'b1;
                    else                    frame_end = 1'b1;
                end else if (is_start) begin
                    idx_d   = 8'd1;
                    restart = 1'b1;
                    err_inc = 1'b1;
                end else if (xgmii_rxc != 8'h00 || idx_q > MAX_WORDS) begin
                    state_d = ST_DROP;
                    idx_d   = 8'd0;
                    err_inc = 1'b1;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            ST_DROP: begin
                if (term_hit || all_idle) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            flags_q  <= '0;
            ts_hi_q  <= 8'd0;
            src_ip_q <= 32'd0;
            lat32_q  <= 32'd0;
        end else if (restart) begin
            flags_q <= '0;
        end else if (data_word) begin
            case (idx_q)
                IDX_ETH: flags_q.eth <= (lane_byte(xgmii_rxd, 4) == 8'h08) &&
                                        (lane_byte(xgmii_rxd, 5) == 8'h00) &&
                                        (lane_byte(xgmii_rxd, 6) == 8'h45);
                IDX_PROTO: flags_q.proto <= (lane_byte(xgmii_rxd, 7) == 8'h11);
                IDX_SRCIP: src_ip_q <= {lane_byte(xgmii_rxd, 2), lane_byte(xgmii_rxd, 3),
                                        lane_byte(xgmii_rxd, 4), lane_byte(xgmii_rxd, 5)};
                IDX_MAGIC: begin
                    flags_q.magic <= ({lane_byte(xgmii_rxd, 2), lane_byte(xgmii_rxd, 3),
                                       lane_byte(xgmii_rxd, 4), lane_byte(xgmii_rxd, 5),
                                       lane_byte(xgmii_rxd, 6)} == MAGIC_CODE);
                    ts_hi_q <= lane_byte(xgmii_rxd, 7);
                end
                IDX_TS: begin
                    flags_q.ts <= 1'b1;
                    // Timestamp and counter are both 32-bit; wrap is intended.
                    lat32_q <= global_counter - {ts_hi_q, lane_byte(xgmii_rxd, 0),
                                                 lane_byte(xgmii_rxd, 1), lane_byte(xgmii_rxd, 2)};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_latency   <= 24'd0;
            rx_lat_valid <= 1'b0;
            rx_ipv4_ip   <= 32'd0;
            rx_err_count <= 16'd0;
        end else begin
            rx_lat_valid <= 1'b0;
            if (frame_end && (&flags_q)) begin
                rx_latency   <= lat_sat;
                rx_ipv4_ip   <= src_ip_q;
                rx_lat_valid <= 1'b1;
            end
            if (err_inc && rx_err_count != 16'hFFFF) rx_err_count <= rx_err_count + 16'd1;
        end
    end

    // A frame finishing on the sec_oneshot cycle seeds the new window.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_acc     <= 32'd0;
            byte_acc      <= 32'd0;
            rx_pps        <= 32'd0;
            rx_throughput <= 32'd0;
        end else if (sec_oneshot) begin
            rx_pps        <= frame_acc;
            rx_throughput <= byte_acc;
            frame_acc     <= frame_end ? 32'd1 : 32'd0;
            byte_acc      <= frame_end ? {16'd0, frame_len} : 32'd0;
        end else if (frame_end) begin
            if (frame_acc != 32'hFFFF_FFFF) frame_acc <= frame_acc + 32'd1;
            byte_acc <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
        end
    end

endmodule

// File: tb/tb_xgmii_rx_latency.sv
// Scoreboard bench for xgmii_rx_latency: generator-style frames in, latency/rate/error results checked.
module tb_xgmii_rx_latency;
    import measure_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        sec_oneshot;
    logic [31:0] global_counter;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip;
    logic [23:0] rx_latency;
    logic        rx_lat_valid;
    logic [15:0] rx_err_count;

    xgmii_rx_latency dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_lat_valid   (rx_lat_valid),
        .rx_ipv4_ip     (rx_ipv4_ip),
        .rx_err_count   (rx_err_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [23:0] lat;
        logic [31:0] ip;
        int          cyc;
    } lat_exp_t;

    typedef struct {
        logic [31:0] pps;
        logic [31:0] thr;
    } rate_exp_t;

    lat_exp_t  lat_q[$];
    rate_exp_t rate_q[$];

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc    = 0;
    logic        sec_d  = 1'b0;
    logic [31:0] exp_frames = 0;
    logic [31:0] exp_bytes  = 0;
    logic [15:0] exp_err    = 0;
    logic [23:0] last_lat   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_latency(input logic [31:0] gc, input logic [31:0] ts);
        logic [31:0] d;
        d = gc - ts;
        return (d > 32'h00FF_FFFF) ? 24'hFF_FFFF : d[23:0];
    endfunction

    always @(posedge sys_clk) begin
        cyc   <= cyc + 1;
        sec_d <= sec_oneshot;
    end

    // Output monitor: pops the scoreboards when the DUT produces results.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rx_lat_valid) begin
                if (lat_q.size() == 0) begin
                    check("spurious_lat_valid", rx_lat_valid, 0);
                end else begin
                    lat_exp_t e;
                    e = lat_q.pop_front();
                    check("rx_latency", rx_latency, e.lat);
                    check("rx_ipv4_ip", rx_ipv4_ip, e.ip);
                    check("lat_valid_cycle", cyc, e.cyc);
                end
            end else if (lat_q.size() != 0 && cyc >= lat_q[0].cyc) begin
                check("lat_valid_missing", rx_lat_valid, 1);
                void'(lat_q.pop_front());
            end
            if (sec_d && rate_q.size() != 0) begin
                rate_exp_t r;
                r = rate_q.pop_front();
                check("rx_pps", rx_pps, r.pps);
                check("rx_throughput", rx_throughput, r.thr);
            end
        end
    end

    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic [31:0] gc, input logic sec);
        @(posedge sys_clk);
        #1;
        xgmii_rxd      = d;
        xgmii_rxc      = c;
        global_counter = gc;
        sec_oneshot    = sec;
    endtask

    task automatic idle(input int n);
        repeat (n) drive({8{XGMII_IDLE}}, 8'hFF, global_counter + 32'd1, 1'b0);
    endtask

    task automatic sec_tick();
        rate_q.push_back('{pps: exp_frames, thr: exp_bytes});
        exp_frames = 0;
        exp_bytes  = 0;
        drive({8{XGMII_IDLE}}, 8'hFF, global_counter + 32'd1, 1'b1);
    endtask

    // 64-byte generator frame; err_idx plants an FE in lane 3 of that word,
    // cut_idx stops driving before that word (next start aborts the frame).
    task automatic send_frame(input logic [31:0] ts, input logic [31:0] gc7, input logic [31:0] ip,
                              input logic bad_magic, input int err_idx, input int cut_idx,
                              input logic sec_at_term);
        logic [7:0]  b[64];
        logic [63:0] w[10];
        logic [7:0]  c[10];
        logic [39:0] magic;
        magic = MAGIC_CODE_DEFAULT;
        for (int p = 0; p < 64; p++) b[p] = 8'(p) ^ 8'h5A;
        b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[23] = 8'h11;
        b[26] = ip[31:24]; b[27] = ip[23:16]; b[28] = ip[15:8]; b[29] = ip[7:0];
        for (int m = 0; m < 5; m++) b[42+m] = magic[39-8*m -: 8];
        if (bad_magic) b[44] = b[44] ^ 8'h01;
        b[47] = ts[31:24]; b[48] = ts[23:16]; b[49] = ts[15:8]; b[50] = ts[7:0];
        w[0] = 64'hD5555555_555555FB; c[0] = 8'h01;
        for (int i = 1; i < 9; i++) begin
            for (int l = 0; l < 8; l++) w[i][8*l +: 8] = b[8*(i-1)+l];
            c[i] = 8'h00;
        end
        w[9] = 64'h07070707_070707FD; c[9] = 8'hFF;
        if (err_idx != 0) begin
            w[err_idx][31:24] = 8'hFE;
            c[err_idx][3]     = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            if (cut_idx != 0 && i == cut_idx) return;
            drive(w[i], c[i], gc7 + 32'(i) - 32'd7, sec_at_term && i == 9);
        end
        if (err_idx == 0) begin
            if (sec_at_term) begin
                rate_q.push_back('{pps: exp_frames, thr: exp_bytes});
                exp_frames = 1;
                exp_bytes  = 64;
            end else begin
                exp_frames = exp_frames + 1;
                exp_bytes  = exp_bytes + 64;
            end
            if (!bad_magic) begin
                last_lat = exp_latency(gc7, ts);
                lat_q.push_back('{lat: last_lat, ip: ip, cyc: cyc + 1});
            end
        end else begin
            exp_err = exp_err + 1;
        end
    endtask

    initial begin
        sys_rst        = 1'b1;
        xgmii_rxd      = {8{XGMII_IDLE}};
        xgmii_rxc      = 8'hFF;
        sec_oneshot    = 1'b0;
        global_counter = 32'd0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_pps", rx_pps, 0);
        check("rst_throughput", rx_throughput, 0);
        check("rst_latency", rx_latency, 0);
        check("rst_lat_valid", rx_lat_valid, 0);
        check("rst_ip", rx_ipv4_ip, 0);
        check("rst_err", rx_err_count, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        idle(4);

        // Basic latency, then three-frame second and an empty second.
        send_frame(32'h0000_1000, 32'h0000_1050, 32'hC0A8_0A01, 0, 0, 0, 0);
        idle(4);
        send_frame(32'h0000_2000, 32'h0000_2123, 32'h0A00_0002, 0, 0, 0, 0);
        idle(3);
        send_frame(32'hFFFF_FFF0, 32'h0000_0010, 32'h0A00_0003, 0, 0, 0, 0);
        idle(3);
        sec_tick();
        idle(3);
        sec_tick();
        idle(3);

        // Saturation, then an untagged frame that must not disturb latency.
        send_frame(32'h0000_0000, 32'h0200_0000, 32'h0A00_0004, 0, 0, 0, 0);
        idle(3);
        send_frame(32'h0000_0500, 32'h0000_0600, 32'h0A00_0005, 1, 0, 0, 0);
        idle(4);
        check("latency_held", rx_latency, last_lat);

        // Error character mid-frame.
        send_frame(32'h0000_0100, 32'h0000_0180, 32'h0A00_0006, 0, 5, 0, 0);
        idle(3);
        check("err_after_fe", rx_err_count, exp_err);

        // Restart mid-frame at idx4.
        send_frame(32'h0000_0100, 32'h0000_0180, 32'h0A00_0007, 0, 0, 4, 0);
        exp_err = exp_err + 1;
        send_frame(32'h1234_0000, 32'h1234_0777, 32'h0A00_0008, 0, 0, 0, 0);
        idle(3);
        check("err_after_abort", rx_err_count, exp_err);

        // Zero-length frame.
        drive(64'hD5555555_555555FB, 8'h01, global_counter + 32'd1, 1'b0);
        drive(64'h07070707_070707FD, 8'hFF, global_counter + 32'd1, 1'b0);
        exp_err = exp_err + 1;
        idle(3);
        check("err_after_len0", rx_err_count, exp_err);

        // Completion coinciding with sec_oneshot lands in the new window.
        send_frame(32'h0000_0040, 32'h0000_0047, 32'h0A00_0009, 0, 0, 0, 1);
        idle(3);
        sec_tick();
        idle(3);

        // Async reset mid-frame.
        send_frame(32'h0000_0000, 32'h0000_0010, 32'h0A00_000A, 0, 0, 5, 0);
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_pps", rx_pps, 0);
        check("arst_throughput", rx_throughput, 0);
        check("arst_latency", rx_latency, 0);
        check("arst_lat_valid", rx_lat_valid, 0);
        check("arst_ip", rx_ipv4_ip, 0);
        check("arst_err", rx_err_count, 0);
        exp_frames = 0;
        exp_bytes  = 0;
        exp_err    = 0;
        last_lat   = 0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        idle(2);
        send_frame(32'h0000_3000, 32'h0000_3033, 32'hAC10_0001, 0, 0, 0, 0);
        idle(4);
        sec_tick();
        idle(3);
        check("err_after_reset", rx_err_count, exp_err);

        idle(2);
        check("lat_queue_drained", lat_q.size(), 0);
        check("rate_queue_drained", rate_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
